neuron_accumulator: RTL and testbench

- Downstream stage of the 16-lane parallel multiply/adder-tree block.
- Consumes one 16-bit signed partial sum per chunk of 16 input neurons and accumulates NUM_CHUNKS partial sums plus a bias into a wide register.
- Saturates the result to 16-bit Q8.8, applies the activation function, and presents the output neuron value on a valid/ready handshake.
- One instance per output-neuron lane; the result feeds the layer's output neuron buffer.

---
 rtl/nn_accel_pkg.sv | 24 ++
 rtl/sat_act_unit.sv | 44 ++++
 rtl/neuron_accumulator.sv | 108 ++++++++++
 tb/tb_neuron_accumulator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_accel_pkg.sv
// rtl/nn_accel_pkg.sv - shared fixed-point constants and state/mode types for the neuron datapath
package nn_accel_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  // +1.0 and -1.0 in Q8.8
  localparam logic [DATA_W-1:0] ONE_FX     = 16'h0100;
  localparam logic [DATA_W-1:0] NEG_ONE_FX = 16'hFF00;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_SIGN  = 2'd1,
    ACT_IDENT = 2'd2
  } act_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ACT   = 2'd2,
    HOLD  = 2'd3
  } acc_state_t;

endpackage

// File: rtl/sat_act_unit.sv
// rtl/sat_act_unit.sv - combinational saturation of the wide accumulator plus activation
//   acc   : signed ACC_W accumulator value
//   value : saturated, activated DATA_W result (signed Q format)
//   sat   : high when acc was outside the DATA_W signed range
module sat_act_unit #(
  parameter int ACC_W    = 24,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACT_MODE = 0
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] value,
  output logic              sat
);
  import nn_accel_pkg::*;

  localparam logic signed [ACC_W-1:0] MAX_ACC = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_ACC = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE_V     = DATA_W'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] NEG_ONE_V = ~ONE_V + DATA_W'(1);
  localparam act_mode_t MODE = act_mode_t'(ACT_MODE[1:0]);

  logic [DATA_W-1:0] clamped;

  always_comb begin
    clamped = acc[DATA_W-1:0];
    sat     = 1'b0;
    if ($signed(acc) > MAX_ACC) begin
      clamped = {1'b0, {(DATA_W-1){1'b1}}};
      sat     = 1'b1;
    end else if ($signed(acc) < MIN_ACC) begin
      clamped = {1'b1, {(DATA_W-1){1'b0}}};
      sat     = 1'b1;
    end

    value = clamped;
    case (MODE)
      ACT_RELU: if (clamped[DATA_W-1]) value = '0;
      ACT_SIGN: value = clamped[DATA_W-1] ? NEG_ONE_V : ONE_V;
      default:  value = clamped;
    endcase
  end

endmodule

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - accumulates NUM_CHUNKS partial sums plus bias, saturates, activates
//   clk, rst            : clock, asynchronous active-high reset
//   psum_in/valid/ready : partial-sum stream from the adder tree
//   bias                : signed bias, taken with the first chunk of a neuron
//   neuron_out/valid/ready : activated result handshake to the output buffer
//   sat                 : result was clamped (qualified by neuron_valid)
//   chunk_cnt           : chunks accepted for the neuron in progress
module neuron_accumulator #(
  parameter int DATA_W     = nn_accel_pkg::DATA_W,
  parameter int FRAC_W     = nn_accel_pkg::FRAC_W,
  parameter int ACC_W      = 24,
  parameter int NUM_CHUNKS = 49,
  parameter int ACT_MODE   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 psum_in,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  input  logic [DATA_W-1:0]                 bias,
  output logic [DATA_W-1:0]                 neuron_out,
  output logic                              neuron_valid,
  input  logic                              neuron_ready,
  output logic                              sat,
  output logic [$clog2(NUM_CHUNKS+1)-1:0]   chunk_cnt
);
  import nn_accel_pkg::*;

  localparam int CNT_W = $clog2(NUM_CHUNKS+1);

  acc_state_t        state, next_state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  psum_ext;
  logic [ACC_W-1:0]  bias_ext;
  logic [DATA_W-1:0] act_value;
  logic              act_sat;
  logic              accept;
  logic              last_chunk;

  assign psum_ext   = {{(ACC_W-DATA_W){psum_in[DATA_W-1]}}, psum_in};
  assign bias_ext   = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign accept     = psum_valid && psum_ready;
  // true when the chunk being accepted is the final one of the neuron
  assign last_chunk = (chunk_cnt == CNT_W'(NUM_CHUNKS-1));

  sat_act_unit #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .ACT_MODE (ACT_MODE)
  ) u_sat_act (
    .acc   (acc),
    .value (act_value),
    .sat   (act_sat)
  );

  always_comb begin
    next_state = state;
    psum_ready = 1'b0;
    case (state)
      IDLE: begin
        psum_ready = 1'b1;
        if (accept) next_state = (NUM_CHUNKS == 1) ? ACT : ACCUM;
      end
      ACCUM: begin
        psum_ready = 1'b1;
        if (accept && last_chunk) next_state = ACT;
      end
      ACT:  next_state = HOLD;
      HOLD: if (neuron_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      chunk_cnt    <= '0;
      neuron_out   <= '0;
      neuron_valid <= 1'b0;
      sat          <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (accept) begin
          acc       <= bias_ext + psum_ext;
          chunk_cnt <= CNT_W'(1);
        end
        ACCUM: if (accept) begin
          acc       <= acc + psum_ext;
          chunk_cnt <= chunk_cnt + CNT_W'(1);
        end
        ACT: begin
          neuron_out   <= act_value;
          sat          <= act_sat;
          neuron_valid <= 1'b1;
        end
        HOLD: if (neuron_ready) begin
          neuron_valid <= 1'b0;
          chunk_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - self-checking bench for neuron_accumulator
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] psum, bias;
  logic        psum_valid, neuron_ready;
  logic [15:0] psum1, bias1;
  logic        psum_valid1, neuron_ready1;

  logic [15:0] out_relu, out_sign, out_ident, out_one;
  logic        valid_relu, valid_sign, valid_ident, valid_one;
  logic        ready_relu, ready_sign, ready_ident, ready_one;
  logic        sat_relu, sat_sign, sat_ident, sat_one;
  logic [2:0]  cnt_relu, cnt_sign, cnt_ident;
  logic [0:0]  cnt_one;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(.ACC_W(24), .NUM_CHUNKS(4), .ACT_MODE(0)) u_relu (
    .clk(clk), .rst(rst), .psum_in(psum), .psum_valid(psum_valid), .psum_ready(ready_relu),
    .bias(bias), .neuron_out(out_relu), .neuron_valid(valid_relu), .neuron_ready(neuron_ready),
    .sat(sat_relu), .chunk_cnt(cnt_relu));

  neuron_accumulator #(.ACC_W(24), .NUM_CHUNKS(4), .ACT_MODE(1)) u_sign (
    .clk(clk), .rst(rst), .psum_in(psum), .psum_valid(psum_valid), .psum_ready(ready_sign),
    .bias(bias), .neuron_out(out_sign), .neuron_valid(valid_sign), .neuron_ready(neuron_ready),
    .sat(sat_sign), .chunk_cnt(cnt_sign));

  neuron_accumulator #(.ACC_W(24), .NUM_CHUNKS(4), .ACT_MODE(2)) u_ident (
    .clk(clk), .rst(rst), .psum_in(psum), .psum_valid(psum_valid), .psum_ready(ready_ident),
    .bias(bias), .neuron_out(out_ident), .neuron_valid(valid_ident), .neuron_ready(neuron_ready),
    .sat(sat_ident), .chunk_cnt(cnt_ident));

  neuron_accumulator #(.ACC_W(24), .NUM_CHUNKS(1), .ACT_MODE(2)) u_one (
    .clk(clk), .rst(rst), .psum_in(psum1), .psum_valid(psum_valid1), .psum_ready(ready_one),
    .bias(bias1), .neuron_out(out_one), .neuron_valid(valid_one), .neuron_ready(neuron_ready1),
    .sat(sat_one), .chunk_cnt(cnt_one));

  // Reference model: chunks accepted so far, running sum as a plain integer,
  // and the pending result once all chunks are in.
  typedef struct {
    int cnt;
    int sum;
    bit valid;
    int out;
    bit sat;
  } mdl_t;

  mdl_t m_relu  = '{default:0};
  mdl_t m_sign  = '{default:0};
  mdl_t m_ident = '{default:0};
  mdl_t m_one   = '{default:0};

  function automatic mdl_t step(mdl_t m, int nc, int mode, bit r, bit pv, int p, int b, bit nr);
    mdl_t nx = m;
    int s;
    if (r) begin
      nx = '{default:0};
      return nx;
    end
    if (m.valid) begin
      if (nr) begin
        nx.valid = 1'b0;
        nx.cnt   = 0;
      end
    end else if (m.cnt == nc) begin
      s = m.sum;
      nx.sat = 1'b0;
      if (s > 32767) begin
        s = 32767;
        nx.sat = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        nx.sat = 1'b1;
      end
      case (mode)
        0:       nx.out = (s < 0) ? 0 : s;
        1:       nx.out = (s >= 0) ? 256 : -256;
        default: nx.out = s;
      endcase
      nx.valid = 1'b1;
    end else if (pv) begin
      nx.sum = (m.cnt == 0) ? (b + p) : (m.sum + p);
      nx.cnt = m.cnt + 1;
    end
    return nx;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_inst(input string nm, input mdl_t m, input int nc, input int cnt,
                          input bit rdy, input bit vld, input logic [15:0] out, input bit st);
    chk({nm, "_chunk_cnt"}, cnt, m.cnt);
    chk({nm, "_psum_ready"}, int'(rdy), int'(!m.valid && m.cnt < nc));
    chk({nm, "_neuron_valid"}, int'(vld), int'(m.valid));
    if (m.valid) begin
      chk({nm, "_neuron_out"}, int'($signed(out)), m.out);
      chk({nm, "_sat"}, int'(st), int'(m.sat));
    end
  endtask

  always @(posedge clk) begin
    m_relu  = step(m_relu,  4, 0, rst, psum_valid, int'($signed(psum)), int'($signed(bias)), neuron_ready);
    m_sign  = step(m_sign,  4, 1, rst, psum_valid, int'($signed(psum)), int'($signed(bias)), neuron_ready);
    m_ident = step(m_ident, 4, 2, rst, psum_valid, int'($signed(psum)), int'($signed(bias)), neuron_ready);
    m_one   = step(m_one,   1, 2, rst, psum_valid1, int'($signed(psum1)), int'($signed(bias1)), neuron_ready1);
    #1;
    chk_inst("relu",  m_relu,  4, int'(cnt_relu),  ready_relu,  valid_relu,  out_relu,  sat_relu);
    chk_inst("sign",  m_sign,  4, int'(cnt_sign),  ready_sign,  valid_sign,  out_sign,  sat_sign);
    chk_inst("ident", m_ident, 4, int'(cnt_ident), ready_ident, valid_ident, out_ident, sat_ident);
    chk_inst("one",   m_one,   1, int'(cnt_one),   ready_one,   valid_one,   out_one,   sat_one);
  end

  task automatic feed(input logic [15:0] b, input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bias       = b;
      psum       = p;
      psum_valid = 1'b1;
    end
  endtask

  // Waits for the result, checks literal outputs, holds backpressure for
  // `hold` cycles (with stray psum_valid pulses), then completes the handshake.
  task automatic finish(input int e_relu, input int e_sign, input int e_ident,
                        input int e_sat, input int hold);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      psum_valid = 1'b0;
      cyc++;
      seen = valid_relu;
    end
    chk("latency", cyc, 2);
    chk("lit_relu_out", int'(out_relu), e_relu);
    chk("lit_sign_out", int'(out_sign), e_sign);
    chk("lit_ident_out", int'(out_ident), e_ident);
    chk("lit_ident_sat", int'(sat_ident), e_sat);
    chk("lit_relu_sat", int'(sat_relu), e_sat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      psum_valid = (i % 2 == 0);
      psum       = 16'h1000;
      chk("hold_psum_ready", int'(ready_relu), 0);
      chk("hold_valid", int'(valid_relu), 1);
      chk("hold_cnt", int'(cnt_relu), 4);
      chk("hold_out", int'(out_relu), e_relu);
    end
    @(negedge clk);
    psum_valid   = 1'b0;
    neuron_ready = 1'b1;
    @(negedge clk);
    neuron_ready = 1'b0;
    chk("post_hs_valid", int'(valid_relu), 0);
    chk("post_hs_cnt", int'(cnt_relu), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 50000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [0:6] pat;
    int k;
    int first;
    int n_acc;

    rst = 1'b1;
    psum = '0; bias = '0; psum_valid = 1'b0; neuron_ready = 1'b0;
    psum1 = '0; bias1 = '0; psum_valid1 = 1'b0; neuron_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out", int'(out_relu), 0);
    chk("rst_valid", int'(valid_relu), 0);
    chk("rst_sat", int'(sat_relu), 0);
    chk("rst_cnt", int'(cnt_relu), 0);
    rst = 1'b0;

    // basic sum: 1.0 + 4 * 1.0
    feed(16'h0100, 16'h0100, 4);
    finish('h0500, 'h0100, 'h0500, 0, 0);

    // negative sum: -4.0
    feed(16'h0000, 16'hFF00, 4);
    finish('h0000, 'hFF00, 'hFC00, 0, 1);

    // positive overflow
    feed(16'h0000, 16'h7000, 4);
    finish('h7FFF, 'h0100, 'h7FFF, 1, 0);

    // negative overflow
    feed(16'h0000, 16'h9000, 4);
    finish('h0000, 'hFF00, 'h8000, 1, 0);

    // bubbles in the psum stream, then 5 cycles of backpressure
    pat = 7'b1001011;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bias       = 16'h0010;
      psum_valid = pat[i];
      psum       = pat[i] ? 16'(256 * (k + 1)) : 16'h7777;
      if (pat[i]) k++;
    end
    finish('h0A10, 'h0100, 'h0A10, 0, 5);

    // reset in the middle of a neuron
    feed(16'h0100, 16'h0100, 2);
    @(negedge clk);
    psum_valid = 1'b0;
    chk("pre_rst_cnt", int'(cnt_relu), 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", int'(cnt_relu), 0);
    chk("mid_rst_valid", int'(valid_relu), 0);
    chk("mid_rst_out", int'(out_relu), 0);
    chk("mid_rst_sat", int'(sat_relu), 0);
    @(negedge clk);
    rst = 1'b0;
    feed(16'h0000, 16'h0080, 4);
    finish('h0200, 'h0100, 'h0200, 0, 0);

    // single-chunk instance, back-to-back neurons with ready tied high
    @(negedge clk);
    bias1 = 16'h0040;
    psum1 = 16'h0040;
    psum_valid1 = 1'b1;
    first = -1;
    n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      if (ready_one) n_acc++;
      if (valid_one && first < 0) begin
        first = i;
        chk("one_lit_out", int'(out_one), 'h0080);
      end
      @(negedge clk);
    end
    psum_valid1 = 1'b0;
    chk("one_latency", first, 2);
    chk("one_accepts", n_acc, 3);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
